fence_ctrl: RTL and testbench
=============================

# fence_ctrl

Sequencer for the serialising instructions retired at commit: FENCE, FENCE.I and SFENCE.VMA. It sits between the commit stage and the memory side. It drains the store buffer, then runs the required D$ flush or L2 fence handshake, and finally issues a one-cycle completion pulse that the commit stage uses as its commit acknowledge.

## Interface
- L2_FENCE_EN, 1, 1 enables the L2 fence handshake for FENCE with non-zero fence_op; 0 skips it and ties l2_fence_valid_o to 0
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- fence_req_i  in  1  level; commit port 0 holds a valid, exception-free FENCE
- fence_i_req_i  in  1  level; commit port 0 holds FENCE.I or a D$ flush request
- sfence_req_i  in  1  level; commit port 0 holds SFENCE.VMA
- fence_op_i  in  2  bit0 = SR (self-invalidate), bit1 = PW (write-back flush); sampled with fence_req_i
- kill_i  in  1  pipeline flush or halt from the controller
- no_st_pending_i  in  1  store buffer empty
- dcache_flush_o  out  1  D$ flush request; level
- dcache_flush_ack_i  in  1  D$ flush complete
- l2_fence_valid_o  out  1  L2 fence request valid
- l2_fence_op_o  out  2  latched fence_op
- l2_fence_ack_i  in  1  L2 fence accepted and complete
- icache_flush_o  out  1  I$ flush pulse
- tlb_flush_o  out  1  TLB flush pulse
- done_o  out  1  one-cycle pulse; commit may acknowledge the instruction
- busy_o  out  1  state != IDLE
- busy_cycles_o  out  32  saturating count of cycles with busy_o = 1

## Operation
- States:
  - IDLE
  - DRAIN
  - DC_FLUSH
  - L2_FENCE
  - DONE
- IDLE: on any request, latch the kind and fence_op_i, then go to DRAIN.
  - If several requests are high at once, the priority is fence_i > sfence > fence.
  - Requests are ignored in all other states.
- DRAIN: wait for no_st_pending_i = 1, then go to:
  - FENCE.I → DC_FLUSH
  - FENCE with L2_FENCE_EN = 1 and latched op != 0 → L2_FENCE
  - otherwise → DONE
- DC_FLUSH: hold dcache_flush_o = 1. Go to DONE in the cycle after dcache_flush_ack_i is sampled high.
- L2_FENCE: hold l2_fence_valid_o = 1 with l2_fence_op_o stable. Go to DONE in the cycle after l2_fence_ack_i is sampled high.
- DONE: pulse done_o for the latched kind only, then return to IDLE.
  - FENCE.I additionally pulses icache_flush_o.
  - SFENCE.VMA additionally pulses tlb_flush_o.
- Acks received outside their own state are ignored.
- kill_i behaviour:
  - In DRAIN: go to IDLE next cycle; no done_o and no flush pulses.
  - In DC_FLUSH or L2_FENCE: set a killed flag. The handshake still completes (outputs stay held until ack), then DONE suppresses done_o, icache_flush_o and tlb_flush_o.
  - The killed flag clears in IDLE.
- busy_cycles_o increments on every cycle with busy_o = 1 and saturates at 0xFFFF_FFFF. It is cleared only by reset.

## Timing
- Reset: state IDLE, every output 0, latched op 0, killed flag 0, busy_cycles_o 0.
- Minimum latency: request high in cycle N (IDLE) → DRAIN in N+1 → DONE in N+2 if no_st_pending_i = 1 in N+1. done_o = 1 in N+2.
- FENCE.I with an immediate ack: DC_FLUSH in N+2, ack in N+2, DONE and done_o in N+3.
- A request still high in the DONE cycle does not restart the sequence. The state is IDLE in DONE+1, and a request in DONE+1 is a new instruction.
- dcache_flush_o and l2_fence_valid_o never deassert before their ack and are never high at the same time.
- Reset asserted mid-operation returns the block to IDLE at once, with all outputs low and no completion pulse.

## Test plan
- FENCE, op = 0, no_st_pending_i = 1: done_o in cycle N+2; no L2, D$ or I$ activity; busy_cycles_o = 2.
- FENCE, op = 2'b11, stores pending for 5 cycles, l2_fence_ack_i 3 cycles after valid:
  - l2_fence_valid_o high for 4 cycles with l2_fence_op_o = 3
  - done_o exactly once, then IDLE
- FENCE.I with dcache_flush_ack_i after 10 cycles: dcache_flush_o high for 10 cycles, then icache_flush_o and done_o pulse together.
- SFENCE.VMA and FENCE requested in the same cycle: sfence sequence runs; tlb_flush_o and done_o pulse together; the FENCE is not serviced.
- kill_i in DRAIN → IDLE next cycle with no done_o. kill_i during DC_FLUSH → flush still held until ack, then no done_o and no icache_flush_o.
- busy_cycles_o preloaded near saturation, run a FENCE.I: counter stops at 0xFFFF_FFFF. Assert rst_ni mid-L2_FENCE: all outputs drop to 0 asynchronously.

Source files
------------

// File: rtl/fence_ctrl_if.sv
// Commit-side and memory-side signals of the fence sequencer.
// fence_ctrl connects through the slave modport; the surrounding pipeline drives the master side.
interface fence_ctrl_if;
  logic        fence_req_i;
  logic        fence_i_req_i;
  logic        sfence_req_i;
  logic [1:0]  fence_op_i;
  logic        kill_i;
  logic        no_st_pending_i;
  logic        dcache_flush_o;
  logic        dcache_flush_ack_i;
  logic        l2_fence_valid_o;
  logic [1:0]  l2_fence_op_o;
  logic        l2_fence_ack_i;
  logic        icache_flush_o;
  logic        tlb_flush_o;
  logic        done_o;
  logic        busy_o;
  logic [31:0] busy_cycles_o;

  modport master (
    output fence_req_i, fence_i_req_i, sfence_req_i, fence_op_i, kill_i, no_st_pending_i,
           dcache_flush_ack_i, l2_fence_ack_i,
    input  dcache_flush_o, l2_fence_valid_o, l2_fence_op_o, icache_flush_o, tlb_flush_o,
           done_o, busy_o, busy_cycles_o
  );

  modport slave (
    input  fence_req_i, fence_i_req_i, sfence_req_i, fence_op_i, kill_i, no_st_pending_i,
           dcache_flush_ack_i, l2_fence_ack_i,
    output dcache_flush_o, l2_fence_valid_o, l2_fence_op_o, icache_flush_o, tlb_flush_o,
           done_o, busy_o, busy_cycles_o
  );
endinterface

// File: rtl/fence_ctrl.sv
// Sequencer for FENCE / FENCE.I / SFENCE.VMA at commit: drain stores, run the D$ flush or
// L2 fence handshake, then pulse done_o (and the I$/TLB flush) as the commit acknowledge.
module fence_ctrl #(
  parameter bit L2_FENCE_EN = 1'b1
) (
  input logic        clk_i,
  input logic        rst_ni,
  fence_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DRAIN, DC_FLUSH, L2_FENCE, DONE} state_t;
  typedef enum logic [1:0] {KIND_FENCE, KIND_FENCE_I, KIND_SFENCE} kind_t;

  state_t      state;
  kind_t       kind;
  logic [1:0]  op_q;
  logic        killed;
  logic        dc_flush;
  logic        l2_valid;
  logic        ic_flush;
  logic        tlb_flush;
  logic        done;
  logic        busy;
  logic [31:0] busy_cnt;

  logic any_req;
  logic l2_needed;
  logic quiet;

  assign any_req   = bus.fence_req_i | bus.fence_i_req_i | bus.sfence_req_i;
  assign l2_needed = L2_FENCE_EN && (kind == KIND_FENCE) && (op_q != 2'b00);
  // A kill seen in the final handshake cycle must also silence the completion.
  assign quiet     = killed | bus.kill_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      kind      <= KIND_FENCE;
      op_q      <= 2'b00;
      killed    <= 1'b0;
      dc_flush  <= 1'b0;
      l2_valid  <= 1'b0;
      ic_flush  <= 1'b0;
      tlb_flush <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      busy_cnt  <= 32'd0;
    end else begin
      ic_flush  <= 1'b0;
      tlb_flush <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          killed <= 1'b0;
          if (any_req) begin
            if (bus.fence_i_req_i)     kind <= KIND_FENCE_I;
            else if (bus.sfence_req_i) kind <= KIND_SFENCE;
            else                       kind <= KIND_FENCE;
            op_q  <= bus.fence_op_i;
            state <= DRAIN;
            busy  <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.kill_i) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bus.no_st_pending_i) begin
            if (kind == KIND_FENCE_I) begin
              state    <= DC_FLUSH;
              dc_flush <= 1'b1;
            end else if (l2_needed) begin
              state    <= L2_FENCE;
              l2_valid <= 1'b1;
            end else begin
              state     <= DONE;
              done      <= 1'b1;
              tlb_flush <= (kind == KIND_SFENCE);
            end
          end
        end
        DC_FLUSH: begin
          if (bus.kill_i) killed <= 1'b1;
          if (bus.dcache_flush_ack_i) begin
            state     <= DONE;
            dc_flush  <= 1'b0;
            done      <= !quiet;
            ic_flush  <= !quiet && (kind == KIND_FENCE_I);
            tlb_flush <= !quiet && (kind == KIND_SFENCE);
          end
        end
        L2_FENCE: begin
          if (bus.kill_i) killed <= 1'b1;
          if (bus.l2_fence_ack_i) begin
            state    <= DONE;
            l2_valid <= 1'b0;
            done     <= !quiet;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          dc_flush <= 1'b0;
          l2_valid <= 1'b0;
        end
      endcase
      if (busy && (busy_cnt != 32'hFFFF_FFFF)) busy_cnt <= busy_cnt + 32'd1;
    end
  end

  assign bus.dcache_flush_o   = dc_flush;
  assign bus.l2_fence_valid_o = l2_valid;
  assign bus.l2_fence_op_o    = op_q;
  assign bus.icache_flush_o   = ic_flush;
  assign bus.tlb_flush_o      = tlb_flush;
  assign bus.done_o           = done;
  assign bus.busy_o           = busy;
  assign bus.busy_cycles_o    = busy_cnt;

endmodule

// File: tb/tb_fence_ctrl.sv
// Bench for fence_ctrl: each directed instruction is expanded into an expected per-cycle
// timeline (drain length, handshake length, kill point) that a negedge process compares against.
module tb_fence_ctrl;

  logic clk;
  logic rst_n;

  fence_ctrl_if bus ();

  fence_ctrl #(.L2_FENCE_EN(1'b1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit prev_busy = 1'b0;
  logic e_dc, e_l2, e_ic, e_tlb, e_done, e_busy;
  logic [1:0] e_op;
  logic [31:0] model_cnt = 32'd0;
  int tot_dc = 0, tot_l2 = 0, tot_ic = 0, tot_tlb = 0, tot_done = 0, last_done = -1;
  int s_dc, s_l2, s_ic, s_tlb, s_done;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_idle();
    bus.fence_req_i        = 1'b0;
    bus.fence_i_req_i      = 1'b0;
    bus.sfence_req_i       = 1'b0;
    bus.fence_op_i         = 2'b00;
    bus.kill_i             = 1'b0;
    bus.no_st_pending_i    = 1'b0;
    bus.dcache_flush_ack_i = 1'b0;
    bus.l2_fence_ack_i     = 1'b0;
  endtask

  // Per-cycle comparison of every output against the timeline expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput($sformatf("cycle %0d {dc,l2,ic,tlb,done,busy}", cyc),
                  {26'd0, bus.dcache_flush_o, bus.l2_fence_valid_o, bus.icache_flush_o,
                   bus.tlb_flush_o, bus.done_o, bus.busy_o},
                  {26'd0, e_dc, e_l2, e_ic, e_tlb, e_done, e_busy});
      checkOutput($sformatf("cycle %0d busy_cycles", cyc), bus.busy_cycles_o, model_cnt);
      if (e_l2) checkOutput($sformatf("cycle %0d l2_fence_op", cyc),
                            {30'd0, bus.l2_fence_op_o}, {30'd0, e_op});
      if (bus.dcache_flush_o)   tot_dc++;
      if (bus.l2_fence_valid_o) tot_l2++;
      if (bus.icache_flush_o)   tot_ic++;
      if (bus.tlb_flush_o)      tot_tlb++;
      if (bus.done_o) begin
        tot_done++;
        last_done = cyc;
      end
    end
  end

  // mask: bit0 FENCE, bit1 FENCE.I, bit2 SFENCE. pend = DRAIN cycles with stores pending,
  // h = handshake cycles (ack in the last), kill_c / abort_c = cycle index or -1.
  task automatic applyStimulus(input logic [2:0] mask, input logic [1:0] op, input int pend,
                               input int h, input int kill_c, input bit hold, input bit spur,
                               input int abort_c);
    int kind, hs0, done_c, last, drain_end;
    bit dc, l2, drain_kill, hs_kill, reqon, in_drain, in_hs;
    kind       = mask[1] ? 1 : (mask[2] ? 2 : 0);
    dc         = (kind == 1);
    l2         = (kind == 0) && (op != 2'b00);
    hs0        = pend + 2;
    drain_kill = (kill_c >= 1) && (kill_c <= pend + 1);
    hs_kill    = !drain_kill && (dc || l2) && (kill_c >= hs0) && (kill_c < hs0 + h);
    done_c     = (dc || l2) ? hs0 + h : pend + 2;
    last       = drain_kill ? kill_c : done_c;
    drain_end  = drain_kill ? kill_c : pend + 1;
    s_dc = tot_dc; s_l2 = tot_l2; s_ic = tot_ic; s_tlb = tot_tlb; s_done = tot_done;
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == abort_c) begin
        checkOutput("pre-reset l2_fence_valid", {31'd0, bus.l2_fence_valid_o}, 32'd1);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset {dc,l2,ic,tlb,done,busy}",
                    {26'd0, bus.dcache_flush_o, bus.l2_fence_valid_o, bus.icache_flush_o,
                     bus.tlb_flush_o, bus.done_o, bus.busy_o}, 32'd0);
        checkOutput("async reset l2_fence_op", {30'd0, bus.l2_fence_op_o}, 32'd0);
        checkOutput("async reset busy_cycles", bus.busy_cycles_o, 32'd0);
        model_cnt = 32'd0;
        prev_busy = 1'b0;
        drive_idle();
        return;
      end
      cyc = c;
      if (prev_busy && (model_cnt != 32'hFFFF_FFFF)) model_cnt = model_cnt + 32'd1;
      reqon    = (c == 0) || (hold && (c <= done_c));
      in_drain = (c >= 1) && (c <= drain_end);
      in_hs    = !drain_kill && (dc || l2) && (c >= hs0) && (c < hs0 + h);
      bus.fence_req_i        = reqon && mask[0];
      bus.fence_i_req_i      = reqon && mask[1];
      bus.sfence_req_i       = reqon && mask[2];
      bus.fence_op_i         = reqon ? op : 2'b00;
      bus.no_st_pending_i    = (c > pend);
      bus.kill_i             = (c == kill_c);
      bus.dcache_flush_ack_i = (dc && in_hs && (c == hs0 + h - 1)) || (spur && in_drain);
      bus.l2_fence_ack_i     = (l2 && in_hs && (c == hs0 + h - 1)) || (spur && in_drain);
      e_busy = (c >= 1) && (c <= last);
      e_dc   = dc && in_hs;
      e_l2   = l2 && in_hs;
      e_op   = op;
      e_done = !drain_kill && (c == done_c) && !hs_kill;
      e_ic   = e_done && (kind == 1);
      e_tlb  = e_done && (kind == 2);
      prev_busy = e_busy;
      chk_en = 1'b1;
    end
    drive_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    checkOutput("reset {dc,l2,ic,tlb,done,busy}",
                {26'd0, bus.dcache_flush_o, bus.l2_fence_valid_o, bus.icache_flush_o,
                 bus.tlb_flush_o, bus.done_o, bus.busy_o}, 32'd0);
    checkOutput("reset busy_cycles", bus.busy_cycles_o, 32'd0);
    checkOutput("reset l2_fence_op", {30'd0, bus.l2_fence_op_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FENCE op 0, stores already drained: minimum latency.
    applyStimulus(3'b001, 2'b00, 0, 1, -1, 1'b0, 1'b0, -1);
    checkOutput("fence min done cycle", last_done, 32'd2);
    checkOutput("fence min busy_cycles", bus.busy_cycles_o, 32'd2);
    checkOutput("fence min l2 cycles", tot_l2 - s_l2, 32'd0);

    // FENCE op 3, five pending cycles, spurious acks during DRAIN, L2 ack 3 cycles after valid.
    applyStimulus(3'b001, 2'b11, 5, 4, -1, 1'b0, 1'b1, -1);
    checkOutput("fence l2 valid cycles", tot_l2 - s_l2, 32'd4);
    checkOutput("fence l2 done count", tot_done - s_done, 32'd1);
    checkOutput("fence l2 done cycle", last_done, 32'd11);

    // FENCE.I with immediate ack.
    applyStimulus(3'b010, 2'b00, 0, 1, -1, 1'b0, 1'b0, -1);
    checkOutput("fence_i fast done cycle", last_done, 32'd3);
    checkOutput("fence_i fast icache pulses", tot_ic - s_ic, 32'd1);

    // FENCE.I with a 10-cycle D$ flush.
    applyStimulus(3'b010, 2'b00, 2, 10, -1, 1'b0, 1'b1, -1);
    checkOutput("fence_i slow dcache cycles", tot_dc - s_dc, 32'd10);
    checkOutput("fence_i slow icache pulses", tot_ic - s_ic, 32'd1);

    // SFENCE and FENCE together, requests held through DONE.
    applyStimulus(3'b101, 2'b01, 0, 1, -1, 1'b1, 1'b0, -1);
    checkOutput("sfence tlb pulses", tot_tlb - s_tlb, 32'd1);
    checkOutput("sfence l2 cycles", tot_l2 - s_l2, 32'd0);
    checkOutput("sfence done count", tot_done - s_done, 32'd1);

    // All three requests: FENCE.I wins.
    applyStimulus(3'b111, 2'b10, 1, 2, -1, 1'b0, 1'b0, -1);
    checkOutput("prio icache pulses", tot_ic - s_ic, 32'd1);
    checkOutput("prio tlb pulses", tot_tlb - s_tlb, 32'd0);

    // Kill in DRAIN.
    applyStimulus(3'b010, 2'b00, 3, 4, 2, 1'b0, 1'b0, -1);
    checkOutput("drain kill done count", tot_done - s_done, 32'd0);

    // Kill during DC_FLUSH: flush held to ack, no completion.
    applyStimulus(3'b010, 2'b00, 0, 6, 3, 1'b0, 1'b0, -1);
    checkOutput("dc kill dcache cycles", tot_dc - s_dc, 32'd6);
    checkOutput("dc kill icache pulses", tot_ic - s_ic, 32'd0);
    checkOutput("dc kill done count", tot_done - s_done, 32'd0);

    // Kill in the same cycle as the L2 ack.
    applyStimulus(3'b001, 2'b10, 1, 3, 5, 1'b0, 1'b0, -1);
    checkOutput("l2 kill valid cycles", tot_l2 - s_l2, 32'd3);
    checkOutput("l2 kill done count", tot_done - s_done, 32'd0);

    // A following FENCE completes normally.
    applyStimulus(3'b001, 2'b00, 0, 1, -1, 1'b0, 1'b0, -1);
    checkOutput("after kill done count", tot_done - s_done, 32'd1);

    // Counter preloaded near saturation, then a long FENCE.I.
    chk_en = 1'b0;
    @(negedge clk);
    force dut.busy_cnt = 32'hFFFF_FFF8;
    @(posedge clk);
    #1;
    release dut.busy_cnt;
    model_cnt = 32'hFFFF_FFF8;
    applyStimulus(3'b010, 2'b00, 2, 10, -1, 1'b0, 1'b0, -1);
    checkOutput("saturated busy_cycles", bus.busy_cycles_o, 32'hFFFF_FFFF);

    // Reset asserted while in L2_FENCE.
    applyStimulus(3'b001, 2'b01, 0, 5, -1, 1'b0, 1'b0, 3);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(3'b001, 2'b00, 0, 1, -1, 1'b0, 1'b0, -1);
    checkOutput("post-reset busy_cycles", bus.busy_cycles_o, 32'd2);
    checkOutput("post-reset done count", tot_done - s_done, 32'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
